nthash_feeder: RTL
==================

// Module: nthash_feeder
// PURPOSE
//  Initiator for the md4block engine: collects an ASCII password one character per beat, expands it
//  to UTF-16LE, builds the single padded 512-bit MD4 block, launches md4block with the standard MD4
//  IV, waits for completion and presents the 128-bit NT hash. It sits between the candidate generator
//  and md4block in the cracking pipeline.
// PARAMETERS
//  MAX_CHARS  27  max password length in characters; must be 1..27 (54 B + 0x80 + 8 B length <= 64 B)
// PORTS
//  clk              in   1    clock, all logic on rising edge
//  rst_n            in   1    asynchronous reset, active low
//  char_valid       in   1    character beat valid
//  char_ready       out  1    block accepts a beat (COLLECT state only)
//  char_data        in   8    ASCII character; 8'h00 = terminator, never appended
//  char_last        in   1    beat is the final beat of the password
//  hash_valid       out  1    hash/hash_err valid, held until accepted
//  hash_ready       in   1    consumer accepts the hash
//  hash             out  128  NT hash, first digest byte in [127:120]
//  hash_err         out  1    password exceeded MAX_CHARS and was truncated
//  busy             out  1    high in every state except COLLECT with count==0
//  md4_irdy         out  1    one-cycle start pulse to md4block
//  md4_state_a..d   out  32   IV: 67452301, efcdab89, 98badcfe, 10325476 (constant)
//  md4_data         out  512  message block; message byte i at [511-8i -: 8]
//  md4_ordy         in   1    md4block done pulse
//  md4_newstate_a..d in  32   md4block result, sampled when md4_ordy==1
// BEHAVIOUR
//  Reset: state=COLLECT, count=0, overflow=0, buffer=0, char_ready=1, hash_valid=0, hash=0,
//   hash_err=0, md4_irdy=0, busy=0. State constants drive md4_state_a..d at all times.
//  COLLECT: char_ready=1. Beat accepted when char_valid&char_ready.
//   - char_data!=0 and count<MAX_CHARS: byte[2*count]=char_data, byte[2*count+1]=0, count++.
//   - char_data!=0 and count==MAX_CHARS: character dropped, overflow<=1.
//   - char_data==0: nothing appended (terminator; empty password = one {00,last} beat).
//   - char_last=1 on an accepted beat -> PAD (the beat's character is appended first).
//  PAD (1 cycle): byte[2*count]=8'h80; bit length L=count*16 written little-endian:
//   byte[56]=L[7:0], byte[57]=L[15:8], bytes 58..63=0. char_ready=0. -> START.
//  START (1 cycle): md4_irdy=1. -> WAIT.
//  WAIT: md4_irdy=0; md4_data and md4_state_* held stable (md4block reads them every step).
//   On md4_ordy: hash<={bswap32(newstate_a),bswap32(b),bswap32(c),bswap32(d)}, hash_err<=overflow,
//   hash_valid<=1 -> DONE. Nominal latency irdy->ordy is 51 cycles; no timeout, no count assumption.
//  DONE: hash, hash_err stable while hash_valid=1. On hash_ready: hash_valid<=0, buffer<=0,
//   count<=0, overflow<=0 -> COLLECT (char_ready=1 the following cycle, not same cycle).
//  md4_ordy outside WAIT is ignored (md4block has no reset and may finish a job after our reset).
//  Reset mid-operation: all state returns to reset values immediately; a stale md4_ordy arriving
//   later is ignored per above; next password is hashed correctly.
//  Only one block in flight; no new irdy is issued until the current hash is handed off.
//  Throughput per password: N beats + 1 (PAD) + 1 (START) + ~51 (WAIT) + >=1 (DONE).
// TESTING
//  1 empty: beat {00,last} -> hash=31d6cfe0d16ae931b73c59d7e0c089c0, hash_err=0, md4_data byte0=80.
//  2 "password" 8 beats, last on 'd' -> hash=8846f7eaee8fb117ad06bdd830b7586c; byte[56]=80h,[57]=00.
//  3 27x'a' -> hash matches C reference model, byte[54]=80h, byte[56]=B0h, byte[57]=01h, hash_err=0.
//  4 28x'a' -> hash identical to test 3, hash_err=1; next password clears hash_err to 0.
//  5 hash_ready held low 20 cycles -> hash_valid/hash stable, char_ready=0 throughout; random
//    char_valid gaps during COLLECT do not change result of test 2.
//  6 rst_n low 1 cycle during WAIT, md4block keeps running -> stale md4_ordy ignored, no hash_valid;
//    then "password" -> correct hash from test 2.

Source files
------------

// File: rtl/nthash_feeder.sv
// nthash_feeder
//   Front end for the md4block engine in the NT-hash cracking pipeline.
//   It collects an ASCII password one character per beat and widens each
//   character to UTF-16LE. It then builds the single padded 512-bit MD4
//   block, starts md4block with the standard IV and waits for it to finish.
//   The resulting 128-bit NT hash is held until the consumer takes it.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   char_valid/ready        character beat handshake (ready only while collecting)
//   char_data, char_last    ASCII byte (8'h00 = terminator), final-beat marker
//   hash_valid/ready        result handshake; hash/hash_err held while valid
//   hash, hash_err          NT hash (first digest byte in [127:120]), truncation flag
//   busy                    low only when idle with an empty buffer
//   md4_irdy                one-cycle start pulse to md4block
//   md4_state_a..d          constant MD4 initial state
//   md4_data                message block, message byte i at [511-8i -: 8]
//   md4_ordy                md4block done pulse
//   md4_newstate_a..d       md4block result, valid with md4_ordy
module nthash_feeder #(
   parameter int MAX_CHARS = 27
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         char_valid,
   output logic         char_ready,
   input  logic [7:0]   char_data,
   input  logic         char_last,
   output logic         hash_valid,
   input  logic         hash_ready,
   output logic [127:0] hash,
   output logic         hash_err,
   output logic         busy,
   output logic         md4_irdy,
   output logic [31:0]  md4_state_a,
   output logic [31:0]  md4_state_b,
   output logic [31:0]  md4_state_c,
   output logic [31:0]  md4_state_d,
   output logic [511:0] md4_data,
   input  logic         md4_ordy,
   input  logic [31:0]  md4_newstate_a,
   input  logic [31:0]  md4_newstate_b,
   input  logic [31:0]  md4_newstate_c,
   input  logic [31:0]  md4_newstate_d
);

   localparam int CW = $clog2(MAX_CHARS + 1);

   typedef enum logic [2:0] {
      S_COLLECT,
      S_PAD,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t         state_reg;
   logic [CW-1:0]  count_reg;
   logic           overflow_reg;
   logic [511:0]   buffer_reg;
   logic           char_ready_reg;
   logic           hash_valid_reg;
   logic [127:0]   hash_reg;
   logic           hash_err_reg;
   logic           md4_irdy_reg;

   // MSB of message byte 2*count, i.e. where the next UTF-16LE code unit
   // (or the 0x80 pad marker) lands.
   logic [8:0]     char_hi;
   logic [15:0]    bit_len;
   logic [127:0]   hash_next;
   logic [31:0]    newstate [4];

   assign char_hi = 9'(511 - 16 * int'(count_reg));
   assign bit_len = 16'(count_reg) << 4;

   // The MD4 digest is the state words serialised little-endian, so each
   // word is byte-swapped to put the first digest byte at the top.
   assign newstate[0] = md4_newstate_a;
   assign newstate[1] = md4_newstate_b;
   assign newstate[2] = md4_newstate_c;
   assign newstate[3] = md4_newstate_d;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bswap
         assign hash_next[127-32*gi -: 32] = {newstate[gi][7:0],   newstate[gi][15:8],
                                              newstate[gi][23:16], newstate[gi][31:24]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_COLLECT;
         count_reg      <= '0;
         overflow_reg   <= 1'b0;
         buffer_reg     <= '0;
         char_ready_reg <= 1'b1;
         hash_valid_reg <= 1'b0;
         hash_reg       <= '0;
         hash_err_reg   <= 1'b0;
         md4_irdy_reg   <= 1'b0;
      end else begin
         md4_irdy_reg <= 1'b0;
         case (state_reg)
            S_COLLECT: begin
               if (char_valid) begin
                  if (char_data != 8'h00) begin
                     if (count_reg < CW'(MAX_CHARS)) begin
                        buffer_reg[char_hi -: 16] <= {char_data, 8'h00};
                        count_reg                 <= CW'(count_reg + 1'b1);
                     end else begin
                        overflow_reg <= 1'b1;
                     end
                  end
                  if (char_last) begin
                     char_ready_reg <= 1'b0;
                     state_reg      <= S_PAD;
                  end
               end
            end
            S_PAD: begin
               buffer_reg[char_hi -: 8] <= 8'h80;
               buffer_reg[63:56]        <= bit_len[7:0];
               buffer_reg[55:48]        <= bit_len[15:8];
               buffer_reg[47:0]         <= '0;
               md4_irdy_reg             <= 1'b1;
               state_reg                <= S_START;
            end
            S_START: begin
               state_reg <= S_WAIT;
            end
            S_WAIT: begin
               // md4block has no reset, so a done pulse is only trusted here.
               if (md4_ordy) begin
                  hash_reg       <= hash_next;
                  hash_err_reg   <= overflow_reg;
                  hash_valid_reg <= 1'b1;
                  state_reg      <= S_DONE;
               end
            end
            S_DONE: begin
               if (hash_ready) begin
                  hash_valid_reg <= 1'b0;
                  buffer_reg     <= '0;
                  count_reg      <= '0;
                  overflow_reg   <= 1'b0;
                  char_ready_reg <= 1'b1;
                  state_reg      <= S_COLLECT;
               end
            end
            default: begin
               state_reg <= S_COLLECT;
            end
         endcase
      end
   end

   assign char_ready  = char_ready_reg;
   assign hash_valid  = hash_valid_reg;
   assign hash        = hash_reg;
   assign hash_err    = hash_err_reg;
   assign md4_irdy    = md4_irdy_reg;
   assign md4_data    = buffer_reg;
   assign busy        = !(state_reg == S_COLLECT && count_reg == '0);

   assign md4_state_a = 32'h67452301;
   assign md4_state_b = 32'hefcdab89;
   assign md4_state_c = 32'h98badcfe;
   assign md4_state_d = 32'h10325476;

endmodule
